regfile_sb: RTL

Parametrised multi-port integer register file with an integrated scoreboard for the riscv-small core. It provides NRD combinational read ports and NWR synchronous write ports with same-cycle write-to-read bypass. A per-register busy bit is set when an instruction issues and cleared on its writeback, which lets the decode stage stall on RAW hazards for multi-cycle producers (loads, mul/div). It is the next generation of the core's 2R/1W register file and sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_sb.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and an
// issue/writeback scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [NRD*AW-1:0]     rs_addr,
  output logic [NRD*XLEN-1:0]   rs_data,
  output logic [NRD-1:0]        rs_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  // x0 has no storage; the array starts at 1
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic [AW-1:0]    wa     [NWR];
  logic [XLEN-1:0]  wd     [NWR];
  logic [NWR-1:0]   wr_eff;
  logic [NREGS-1:0] busy_nxt;

  logic [AW-1:0]    ra     [NRD];
  logic [XLEN-1:0]  rd_val [NRD];
  logic [NRD-1:0]   rd_hit;
  logic [NRD-1:0]   rd_bsy;

  // Unpack write ports and qualify them
  always_comb begin
    for (int unsigned j = 0; j < NWR; j++) begin
      wa[j]     = wr_addr[j*AW +: AW];
      wd[j]     = wr_data[j*XLEN +: XLEN];
      wr_eff[j] = clk_en && wr_en[j] && (wa[j] != '0);
    end
  end

  // Read ports: storage, then bypass; later write ports overwrite earlier ones
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra[i]     = rs_addr[i*AW +: AW];
      rd_val[i] = '0;
      rd_hit[i] = 1'b0;
      rd_bsy[i] = 1'b0;
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (ra[i] == AW'(r)) begin
          rd_val[i] = regs[r];
          rd_bsy[i] = busy_vec[r];
        end
      end
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_eff[j] && (wa[j] == ra[i])) begin
          rd_val[i] = wd[j];
          rd_hit[i] = 1'b1;
        end
      end
      rs_data[i*XLEN +: XLEN] = rd_val[i];
      rs_busy[i]              = rd_bsy[i] && !rd_hit[i];
    end
  end

  // Scoreboard next state: writeback clears, issue sets, flush wipes all
  always_comb begin
    busy_nxt = busy_vec;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_eff[j]) busy_nxt[wa[j]] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NREGS; r++) regs[r] <= '0;
      busy_vec <= '0;
    end else if (clk_en) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (wr_eff[j] && (wa[j] == AW'(r))) regs[r] <= wd[j];
        end
      end
      busy_vec <= busy_nxt;
    end
  end

endmodule
